// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the single-cycle MIPS core: next-PC select, stall/halt FSM, pending redirect.
// Optional performance counters (instr_cnt, redirect_cnt) are built only when PC_PERF_CNT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        branch,
  input  logic        jr,
  input  logic        jmp,
  input  logic [15:0] imm16,
  input  logic [25:0] target,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        addr_err
`ifdef PC_PERF_CNT_EN
  , output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_addr;

  logic [31:0] branch_addr_c;
  logic [31:0] jmp_addr_c;
  logic [31:0] redir_raw_c;
  logic [31:0] redir_addr_c;
  logic        redirect_c;
  logic        redir_mis_c;

  assign pc_plus_4   = pc + 32'd4;
  assign fetch_valid = (state == RUN) && !stall && !rst;

  // Redirect candidate in priority order branch > jr > jmp, word-aligned.
  always_comb begin
    branch_addr_c = pc_plus_4 + {{14{imm16[15]}}, imm16, 2'b00};
    jmp_addr_c    = {pc[31:28], target, 2'b00};
    redirect_c    = branch || jr || jmp;
    if (branch)   redir_raw_c = branch_addr_c;
    else if (jr)  redir_raw_c = rs_data;
    else          redir_raw_c = jmp_addr_c;
    redir_addr_c  = {redir_raw_c[31:2], 2'b00};
    redir_mis_c   = redirect_c && (redir_raw_c[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= RUN;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      halted     <= 1'b0;
      addr_err   <= 1'b0;
`ifdef PC_PERF_CNT_EN
      instr_cnt    <= '0;
      redirect_cnt <= '0;
`endif
    end else begin
      addr_err <= 1'b0;
`ifdef PC_PERF_CNT_EN
      if (fetch_valid) instr_cnt <= instr_cnt + CNT_W'(1);
`endif
      case (state)
        RUN: begin
          if (halt || stall) begin
            // A redirect arriving with the hold is parked until the core moves again.
            state  <= halt ? HALT : STALL;
            halted <= halt;
            if (redirect_c) begin
              pend_valid <= 1'b1;
              pend_addr  <= redir_addr_c;
              addr_err   <= redir_mis_c;
            end
          end else if (pend_valid) begin
            pc         <= pend_addr;
            pend_valid <= 1'b0;
`ifdef PC_PERF_CNT_EN
            redirect_cnt <= redirect_cnt + CNT_W'(1);
`endif
          end else if (redirect_c) begin
            pc       <= redir_addr_c;
            addr_err <= redir_mis_c;
`ifdef PC_PERF_CNT_EN
            redirect_cnt <= redirect_cnt + CNT_W'(1);
`endif
          end else begin
            pc <= pc_plus_4;
          end
        end
        STALL: begin
          if (halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (stall) begin
            if (redirect_c) begin
              pend_valid <= 1'b1;
              pend_addr  <= redir_addr_c;
              addr_err   <= redir_mis_c;
            end
          end else begin
            // Leaving the stall re-fetches the held pc unless a redirect is parked.
            state <= RUN;
            if (pend_valid) begin
              pc         <= pend_addr;
              pend_valid <= 1'b0;
`ifdef PC_PERF_CNT_EN
              redirect_cnt <= redirect_cnt + CNT_W'(1);
`endif
            end
          end
        end
        HALT: begin
          if (resume) begin
            state      <= RUN;
            halted     <= 1'b0;
            pend_valid <= 1'b0;
            pc         <= pend_valid ? pend_addr : pc_plus_4;
`ifdef PC_PERF_CNT_EN
            if (pend_valid) redirect_cnt <= redirect_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model predictions, monitor pops and compares each cycle.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, halt, resume, branch, jr, jmp;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] rs_data;
  logic [31:0] pc, pc_plus_4;
  logic        fetch_valid, halted, addr_err;
`ifdef PC_PERF_CNT_EN
  logic [31:0] instr_cnt, redirect_cnt;
`endif

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
    .branch(branch), .jr(jr), .jmp(jmp), .imm16(imm16), .target(target),
    .rs_data(rs_data), .pc(pc), .pc_plus_4(pc_plus_4), .fetch_valid(fetch_valid),
    .halted(halted), .addr_err(addr_err)
`ifdef PC_PERF_CNT_EN
    , .instr_cnt(instr_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        halted;
    logic        aerr;
    logic [31:0] icnt;
    logic [31:0] rcnt;
  } exp_t;

  typedef enum {M_RUN, M_STALL, M_HALT} mode_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          drv_done = 1'b0;

  // Reference model state
  mode_t       m_mode   = M_RUN;
  logic [31:0] m_pc     = RESET_PC;
  bit          m_pend   = 1'b0;
  logic [31:0] m_paddr  = 32'd0;
  bit          m_halted = 1'b0;
  bit          m_aerr   = 1'b0;
  logic [31:0] m_ic     = 32'd0;
  logic [31:0] m_rc     = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit st, input bit h, input bit res,
                       input bit br, input bit j_r, input bit j_m,
                       input logic [15:0] im, input logic [25:0] tg, input logic [31:0] rs);
    exp_t        e;
    bit          red, mis, nerr;
    logic [31:0] tgt, al;
    @(negedge clk);
    rst = r; stall = st; halt = h; resume = res;
    branch = br; jr = j_r; jmp = j_m; imm16 = im; target = tg; rs_data = rs;
    e.fv     = (m_mode == M_RUN) && !st && !r;
    e.pc     = m_pc;
    e.pcp4   = m_pc + 32'd4;
    e.halted = m_halted;
    e.aerr   = m_aerr;
    e.icnt   = m_ic;
    e.rcnt   = m_rc;
    sb.push_back(e);
    if (r) begin
      m_pc = RESET_PC; m_mode = M_RUN; m_pend = 0; m_halted = 0; m_aerr = 0;
      m_ic = 0; m_rc = 0;
    end else begin
      if (e.fv) m_ic = m_ic + 1;
      red = br || j_r || j_m;
      if (br)        tgt = m_pc + 32'd4 + 32'($signed(im)) * 4;
      else if (j_r)  tgt = rs;
      else           tgt = (m_pc & 32'hF000_0000) | (32'(tg) * 4);
      al   = tgt - (tgt % 4);
      mis  = red && (tgt % 4 != 0);
      nerr = 0;
      case (m_mode)
        M_RUN: begin
          if (h || st) begin
            m_mode = h ? M_HALT : M_STALL;
            if (red) begin m_pend = 1; m_paddr = al; nerr = mis; end
          end else if (red) begin
            m_pc = al; nerr = mis; m_rc = m_rc + 1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
        M_STALL: begin
          if (h) m_mode = M_HALT;
          else if (st) begin
            if (red) begin m_pend = 1; m_paddr = al; nerr = mis; end
          end else begin
            m_mode = M_RUN;
            if (m_pend) begin m_pc = m_paddr; m_pend = 0; m_rc = m_rc + 1; end
          end
        end
        default: begin
          if (res) begin
            m_mode = M_RUN;
            if (m_pend) begin m_pc = m_paddr; m_rc = m_rc + 1; end
            else m_pc = m_pc + 32'd4;
            m_pend = 0;
          end
        end
      endcase
      m_halted = (m_mode == M_HALT);
      m_aerr   = nerr;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] a);
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0, 26'h0, a);
  endtask

  // Monitor: samples just after the driver updates inputs, well before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
        chk("pc", pc, e.pc);
        chk("pc_plus_4", pc_plus_4, e.pcp4);
        chk("halted", 32'(halted), 32'(e.halted));
        chk("addr_err", 32'(addr_err), 32'(e.aerr));
`ifdef PC_PERF_CNT_EN
        chk("instr_cnt", instr_cnt, e.icnt);
        chk("redirect_cnt", redirect_cnt, e.rcnt);
`endif
      end
    end
  end

  initial begin
    rst = 1; stall = 0; halt = 0; resume = 0; branch = 0; jr = 0; jmp = 0;
    imm16 = 0; target = 0; rs_data = 0;
    // Reset then free run
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    repeat (4) idle();
    // Negative branch, then branch beats jmp
    jump_to(32'h40);
    drive(0, 0, 0, 0, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0);
    drive(0, 0, 0, 0, 1, 0, 1, 16'h0004, 26'h3FF, 32'h0);
    idle();
    // Redirect during stall applied after stall
    jump_to(32'h100);
    drive(0, 1, 0, 0, 0, 1, 0, 16'h0, 26'h0, 32'h200);
    drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    idle(); idle();
    // Halt with same-cycle jmp, resume takes pending target
    jump_to(32'h20);
    drive(0, 0, 1, 0, 0, 0, 1, 16'h0, 26'h10, 32'h0);
    idle();
    drive(0, 0, 0, 0, 1, 1, 1, 16'h7, 26'h5, 32'h80);
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    idle();
    // Halt without redirect resumes at pc+4
    drive(0, 0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    drive(0, 0, 0, 1, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    idle();
    // Misaligned jr and wrap at top of address space
    jump_to(32'h203);
    idle();
    jump_to(32'hFFFF_FFFC);
    idle(); idle(); idle();
    // Counter scenario then reset mid-halt
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      drive(0, 0, 0, 0, (i == 3 || i == 7), 0, 0, 16'h0002, 26'h0, 32'h0);
    idle();
    drive(0, 0, 1, 0, 0, 1, 0, 16'h0, 26'h0, 32'h300);
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    idle(); idle();
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rs;
      rs = $urandom();
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10, 16'($urandom()), 26'($urandom()), rs);
    end
    idle();
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(drv_done && sb.size() == 0) && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (sb.size() != 0 || !drv_done) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, driver done %0d", sb.size(), drv_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
